sub_sat_stage: RTL and testbench
================================

# sub_sat_stage

Registered output stage placed directly downstream of the 8-bit subtractor. It accepts the subtractor's raw two's-complement difference and overflow flag through a valid/ready handshake, clamps overflowed results to the signed 8-bit limits, buffers results in a 2-entry FIFO, and counts saturation events. It isolates the combinational subtractor from the consumer and removes any combinational ready path from output to input.

## Interface
- CNT_W, 16, width of the saturation-event counter (legal range 4..32)
- clk  input  1  rising-edge clock; the block's only clock
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  upstream presents a result
- in_ready  output  1  stage can accept; depends only on internal state
- diff  input  8  raw difference from the subtractor
- overflow  input  1  signed-overflow flag from the subtractor
- out_valid  output  1  head entry is valid
- out_ready  input  1  consumer accepts the head entry
- out_data  output  8  saturated result
- out_sat  output  1  1 when out_data was clamped
- cnt_clr  input  1  synchronous clear of sat_cnt
- sat_cnt  output  CNT_W  number of accepted saturated samples, sticky at all-ones

## Operation
- Push: in_valid && in_ready at a rising edge. Pop: out_valid && out_ready at a rising edge.
- Saturation is applied on push.
  - overflow=0: stored data = diff, sat=0.
  - overflow=1: stored data = 8'h7F if diff[7]=1 (true result positive), else 8'h80; sat=1.
- The FIFO has 2 entries, a 2-bit occupancy count (0..2), a 1-bit write pointer, and a 1-bit read pointer. Pointers wrap 1→0.
- in_ready = (count != 2). out_valid = (count != 0). out_data/out_sat drive the entry at the read pointer.
- Simultaneous push and pop:
  - count 1: count is unchanged and both pointers advance.
  - count 2: push is impossible because in_ready=0. Only the pop occurs, and in_ready rises the next cycle.
  - count 0: only the push occurs. There is no fall-through; the data becomes visible the next cycle.
- Data in the FIFO is never overwritten or dropped. While out_valid=1 and out_ready=0, out_data and out_sat hold stable.
- sat_cnt:
  - Increments by 1 on each push with overflow=1.
  - Holds at 2^CNT_W-1 and never wraps.
  - cnt_clr=1 sets it to 0 and has priority over a same-cycle increment; that event is not counted.
- Inputs are ignored when in_valid=0 or in_ready=0, including an overflow flag that is not accepted.

## Timing
- Reset (asynchronous assert, synchronous use after deassert):
  - count=0, pointers=0, sat_cnt=0.
  - out_valid=0, in_ready=1, out_data=8'h00, out_sat=0.
  - Storage entries are cleared to 0.
- Latency: a push at edge N gives out_valid=1 with that data after edge N. The minimum is 1 cycle.
- Throughput is 1 sample/cycle sustained when out_ready stays high.
- If rst_n asserts mid-operation, all buffered entries are discarded immediately and outputs take their reset values within the same cycle, without waiting for a clock.
- in_ready has no combinational path from out_ready, in_valid or any data input.
- out_data and out_sat come from registers through the read-pointer mux, with no input-to-output combinational path.

## Test plan
- Plain pass-through, out_ready held 1: push diff=8'h05, overflow=0.
  - Required: out_valid=1 one cycle later with out_data=8'h05, out_sat=0, sat_cnt=0.
- Saturation, both directions: push (diff=8'h80, ov=1), then (diff=8'h7E, ov=1).
  - Required: outputs 8'h7F/sat=1, then 8'h80/sat=1; sat_cnt=2.
- Backpressure, out_ready=0: push A=8'h11, B=8'h22.
  - Required: in_ready=0 after the second push, a third offer (8'h33) is not accepted, and out_data holds 8'h11.
  - Then raise out_ready: outputs are 8'h11, then 8'h22.
  - 8'h33 is accepted one cycle after the first pop.
- Streaming with random out_ready and in_valid over 1000 samples.
  - Required: output order equals input order, no loss or duplication, and saturation results match the rule above.
- Counter boundaries with CNT_W=4: 20 overflow pushes leave sat_cnt=4'hF.
  - cnt_clr coinciding with an overflow push leaves sat_cnt=0.
- Asynchronous reset with 2 entries buffered: assert rst_n=0 between edges.
  - Required: out_valid=0, in_ready=1, out_data=8'h00 and sat_cnt=0 immediately.
  - After release, the first push appears after 1 cycle.

Source files
------------

// File: rtl/sub_sat_stage.sv
// Saturating output stage behind the 8-bit subtractor.
// Clamps overflowed differences, buffers them in a 2-deep FIFO and counts saturations.
module sub_sat_stage #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       diff,
  input  logic             overflow,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic             out_sat,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] sat_cnt
);

  logic [7:0] mem_data [2];
  logic       mem_sat  [2];
  logic [1:0] count;
  logic       wptr;
  logic       rptr;
  logic       push;
  logic       pop;
  logic [7:0] sat_data;

  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_data  = mem_data[rptr];
  assign out_sat   = mem_sat[rptr];

  // diff[7]=1 on overflow means the true result was positive
  always_comb begin
    sat_data = diff;
    if (overflow) begin
      sat_data = diff[7] ? 8'h7F : 8'h80;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        mem_data[i] <= 8'h00;
        mem_sat[i]  <= 1'b0;
      end
      wptr <= 1'b0;
    end else if (push) begin
      mem_data[wptr] <= sat_data;
      mem_sat[wptr]  <= overflow;
      wptr           <= ~wptr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rptr <= 1'b0;
    end else if (pop) begin
      rptr <= ~rptr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 2'd0;
    end else if (push && !pop) begin
      count <= count + 2'd1;
    end else if (pop && !push) begin
      count <= count - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_cnt <= '0;
    end else if (cnt_clr) begin
      sat_cnt <= '0;
    end else if (push && overflow && (sat_cnt != '1)) begin
      sat_cnt <= sat_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_sub_sat_stage.sv
// Directed and randomized-handshake bench for sub_sat_stage.
// Uses CNT_W=4 so the sticky counter limit is reachable.
module tb_sub_sat_stage;

  localparam int CW = 4;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [7:0]    diff;
  logic          overflow;
  logic          out_valid;
  logic          out_ready;
  logic [7:0]    out_data;
  logic          out_sat;
  logic          cnt_clr;
  logic [CW-1:0] sat_cnt;

  int n_vec;
  int n_bad;

  sub_sat_stage #(.CNT_W(CW)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .diff(diff),
    .overflow(overflow),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_sat(out_sat),
    .cnt_clr(cnt_clr),
    .sat_cnt(sat_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [8:0] sat_ref(input logic [7:0] d,
                                         input logic o);
    if (!o) return {1'b0, d};
    if (d[7]) return {1'b1, 8'h7F};
    return {1'b1, 8'h80};
  endfunction

  task automatic offer(input logic [7:0] d, input logic o);
    in_valid = 1'b1;
    diff     = d;
    overflow = o;
  endtask

  logic [8:0] q[$];
  logic [8:0] e;
  int         nacc;
  int         cyc;
  int         mcnt;

  initial begin
    n_vec     = 0;
    n_bad     = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    diff      = 8'h00;
    overflow  = 1'b0;
    out_ready = 1'b0;
    cnt_clr   = 1'b0;
    #12;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_out_sat", 32'(out_sat), 0);
    chk("rst_sat_cnt", 32'(sat_cnt), 0);
    rst_n = 1'b1;
    step();

    // pass-through
    out_ready = 1'b1;
    offer(8'h05, 1'b0);
    step();
    in_valid = 1'b0;
    chk("pass_valid", 32'(out_valid), 1);
    chk("pass_data", 32'(out_data), 32'h05);
    chk("pass_sat", 32'(out_sat), 0);
    chk("pass_cnt", 32'(sat_cnt), 0);
    step();
    chk("pass_empty", 32'(out_valid), 0);

    // saturation both ways, second push overlaps the first pop
    offer(8'h80, 1'b1);
    step();
    chk("satp_data", 32'(out_data), 32'h7F);
    chk("satp_sat", 32'(out_sat), 1);
    offer(8'h7E, 1'b1);
    step();
    in_valid = 1'b0;
    chk("satn_valid", 32'(out_valid), 1);
    chk("satn_data", 32'(out_data), 32'h80);
    chk("satn_sat", 32'(out_sat), 1);
    chk("sat_cnt2", 32'(sat_cnt), 2);
    step();
    chk("sat_empty", 32'(out_valid), 0);

    // backpressure
    out_ready = 1'b0;
    offer(8'h11, 1'b0);
    step();
    offer(8'h22, 1'b0);
    step();
    chk("bp_full", 32'(in_ready), 0);
    chk("bp_head", 32'(out_data), 32'h11);
    offer(8'h33, 1'b0);
    step();
    chk("bp_still_full", 32'(in_ready), 0);
    chk("bp_hold", 32'(out_data), 32'h11);
    out_ready = 1'b1;
    step();
    chk("bp_pop1", 32'(out_data), 32'h22);
    chk("bp_ready_up", 32'(in_ready), 1);
    step();
    in_valid = 1'b0;
    chk("bp_pop2", 32'(out_data), 32'h33);
    chk("bp_valid3", 32'(out_valid), 1);
    step();
    chk("bp_empty", 32'(out_valid), 0);
    chk("bp_cnt", 32'(sat_cnt), 2);

    // streaming with random handshakes
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    chk("clr_cnt", 32'(sat_cnt), 0);
    mcnt = 0;
    nacc = 0;
    cyc  = 0;
    while (nacc < 1000 && cyc < 20000) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      diff      = 8'($urandom);
      overflow  = 1'($urandom);
      if (out_valid !== (q.size() != 0)) begin
        chk("st_valid", 32'(out_valid), 32'(q.size() != 0));
      end
      if (in_ready !== (q.size() != 2)) begin
        chk("st_ready", 32'(in_ready), 32'(q.size() != 2));
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("st_extra", 1, 0);
        end else begin
          e = q.pop_front();
          chk("st_data", {23'd0, out_sat, out_data}, {23'd0, e});
        end
      end
      if (in_valid && in_ready) begin
        q.push_back(sat_ref(diff, overflow));
        nacc++;
        if (overflow && mcnt != 15) mcnt++;
      end
      step();
      cyc++;
    end
    in_valid = 1'b0;
    chk("st_budget", 32'(cyc < 20000), 1);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("dr_extra", 1, 0);
        end else begin
          e = q.pop_front();
          chk("dr_data", {23'd0, out_sat, out_data}, {23'd0, e});
        end
      end
      step();
    end
    chk("dr_left", 32'(q.size()), 0);
    chk("dr_valid", 32'(out_valid), 0);
    chk("st_cnt", 32'(sat_cnt), 32'(mcnt));

    // counter limit and clear priority
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    for (int i = 0; i < 20; i++) begin
      offer(8'(i), 1'b1);
      step();
    end
    in_valid = 1'b0;
    chk("cnt_sticky", 32'(sat_cnt), 32'hF);
    offer(8'h90, 1'b1);
    cnt_clr = 1'b1;
    step();
    in_valid = 1'b0;
    cnt_clr  = 1'b0;
    chk("cnt_clr_prio", 32'(sat_cnt), 0);
    step();
    step();

    // async reset with two entries held
    out_ready = 1'b0;
    offer(8'h01, 1'b1);
    step();
    offer(8'h55, 1'b0);
    step();
    in_valid = 1'b0;
    chk("ar_full", 32'(in_ready), 0);
    chk("ar_head", 32'(out_data), 32'h80);
    chk("ar_cnt", 32'(sat_cnt), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_valid", 32'(out_valid), 0);
    chk("ar_ready", 32'(in_ready), 1);
    chk("ar_data", 32'(out_data), 0);
    chk("ar_sat", 32'(out_sat), 0);
    chk("ar_satcnt", 32'(sat_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("ar_post_valid", 32'(out_valid), 0);
    out_ready = 1'b1;
    offer(8'h66, 1'b0);
    step();
    in_valid = 1'b0;
    chk("ar_push_valid", 32'(out_valid), 1);
    chk("ar_push_data", 32'(out_data), 32'h66);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
